// File: rtl/regfile_mp.sv
// Multi-port GPR file with same-cycle write->read forwarding.
// A sequential clear engine zeroes every entry after reset or on request.
module regfile_mp #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 2,
    parameter bit ZERO_REG       = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    output logic                       ready,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic   RST_READY = !CLEAR_ON_RESET;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];

    logic                run;
    logic                wr_live;

    assign run     = (state_q == ST_RUN);
    assign wr_live = run && !clear_req;
    assign ready   = ready_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        unique case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
            ready_q <= RST_READY;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    // Ascending port order lets the highest-indexed writer win a collision.
    always_comb begin
        regs_d = regs_q;
        if (state_q == ST_INIT) begin
            regs_d[ptr_q] = '0;
        end else if (wr_live) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] &&
                    !(ZERO_REG && wr_addr[p*ADDR_W +: ADDR_W] == '0)) begin
                    regs_d[wr_addr[p*ADDR_W +: ADDR_W]] =
                        wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // The array is deliberately left alone while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= regs_d;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[r*ADDR_W +: ADDR_W];

        always_comb begin
            rv = '0;
            if (run && rd_en[r] && !(ZERO_REG && ra == '0)) begin
                rv = regs_q[ra];
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ra) begin
                        rv = wr_data[p*DATA_W +: DATA_W];
                    end
                end
            end
        end

        assign rd_data[r*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sweep timing, forwarding,
// write priority, zero register, clear request and reset mid-sweep.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic        ready;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;

    int total = 0;
    int bad   = 0;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ready     (ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic en, input logic [4:0] a,
                      input logic [31:0] d);
        wr_en[p]          = en;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input int r, input logic en, input logic [4:0] a);
        rd_en[r]          = en;
        rd_addr[r*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rdv(input int r);
        return rd_data[r*32 +: 32];
    endfunction

    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk(tag, {31'b0, ready}, {31'b0, i == 32});
        end
    endtask

    initial begin
        rst       = 1'b0;
        clear_req = 1'b0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = '0;
        rd_addr   = '0;

        // 1: reset then clear sweep, reads stay 0 throughout
        tick();
        chk("rst_ready", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            rd(0, 1'b1, 5'(i - 1));
            rd(1, 1'b1, 5'(32 - i));
            wr(1, 1'b1, 5'(32 - i), 32'hCAFE_0000 + 32'(i));
            #1;
            chk("init_rd0", rdv(0), 32'd0);
            chk("init_rd1", rdv(1), 32'd0);
            tick();
            chk("init_ready", {31'b0, ready}, {31'b0, i == 32});
        end
        wr(1, 1'b0, 5'd0, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd(0, 1'b1, 5'(a));
            #1;
            chk("post_clear", rdv(0), 32'd0);
        end

        // 2: forwarding then stored value
        wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        rd(0, 1'b1, 5'd5);
        #1;
        chk("fwd5", rdv(0), 32'hDEAD_BEEF);
        tick();
        wr(0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("reg5", rdv(0), 32'hDEAD_BEEF);

        // 3: two writers on one address, port 1 wins
        wr(0, 1'b1, 5'd7, 32'h1111);
        wr(1, 1'b1, 5'd7, 32'h2222);
        rd(1, 1'b1, 5'd7);
        #1;
        chk("fwd7", rdv(1), 32'h2222);
        tick();
        wr(0, 1'b0, 5'd0, 32'd0);
        wr(1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("reg7", rdv(1), 32'h2222);
        chk("reg5b", rdv(0), 32'hDEAD_BEEF);

        // 4: zero register and read enable gating
        wr(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        rd(0, 1'b1, 5'd0);
        #1;
        chk("zero_fwd", rdv(0), 32'd0);
        tick();
        wr(1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("zero_reg", rdv(0), 32'd0);
        wr(0, 1'b1, 5'd5, 32'h1234_5678);
        rd(0, 1'b0, 5'd5);
        rd(1, 1'b0, 5'd7);
        #1;
        chk("rden0_fwd", rdv(0), 32'd0);
        chk("rden1_reg", rdv(1), 32'd0);
        tick();
        wr(0, 1'b0, 5'd0, 32'd0);

        // 5: clear request drops the same-edge write
        wr(0, 1'b1, 5'd3, 32'hA5);
        tick();
        wr(0, 1'b0, 5'd0, 32'd0);
        rd(0, 1'b1, 5'd3);
        #1;
        chk("fill3", rdv(0), 32'hA5);
        clear_req = 1'b1;
        wr(0, 1'b1, 5'd4, 32'h5A);
        tick();
        clear_req = 1'b0;
        wr(0, 1'b0, 5'd0, 32'd0);
        chk("clr_ready", {31'b0, ready}, 32'd0);
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("clr_sweep", {31'b0, ready}, 32'd0);
        end
        tick();
        chk("clr_done", {31'b0, ready}, 32'd1);
        rd(0, 1'b1, 5'd3);
        rd(1, 1'b1, 5'd4);
        #1;
        chk("clr3", rdv(0), 32'd0);
        chk("clr4", rdv(1), 32'd0);
        rd(0, 1'b1, 5'd5);
        rd(1, 1'b1, 5'd7);
        #1;
        chk("clr5", rdv(0), 32'd0);
        chk("clr7", rdv(1), 32'd0);

        // 6: reset at sweep cycle 10, writes during INIT leave no trace
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wr(0, 1'b1, 5'd9, 32'h9999);
        wr(1, 1'b1, 5'd20, 32'h2020);
        rd(0, 1'b1, 5'd9);
        rd(1, 1'b1, 5'd20);
        for (int i = 1; i <= 9; i++) begin
            #1;
            chk("mid_rd0", rdv(0), 32'd0);
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst", {31'b0, ready}, 32'd0);
        for (int i = 1; i <= 32; i++) begin
            #1;
            chk("rerun_rd1", rdv(1), 32'd0);
            tick();
            chk("rerun_ready", {31'b0, ready}, {31'b0, i == 32});
        end
        wr(0, 1'b0, 5'd0, 32'd0);
        wr(1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("trace9", rdv(0), 32'd0);
        chk("trace20", rdv(1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
